// File: rtl/resource_arbiter.sv
// Round-robin read arbiter sharing the flat image/font stores between two renderers.
// Define RESOURCE_ARB_FIXED_PRIO_EN to give port 0 absolute priority instead of round-robin.
`timescale 1ns/1ps

module resource_arbiter #(
    parameter int IMG_LEN  = 4096,
    parameter int IMG_W    = 12,
    parameter int FONT_LEN = 2048,
    parameter int FONT_W   = 8,
    parameter int AW       = 10,
    parameter int DW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IMG_LEN-1:0]  image_data,
    input  logic [FONT_LEN-1:0] font_data,
    input  logic                req0,
    input  logic                src0,
    input  logic [AW-1:0]       addr0,
    output logic                ack0,
    output logic                rvalid0,
    input  logic                req1,
    input  logic                src1,
    input  logic [AW-1:0]       addr1,
    output logic                ack1,
    output logic                rvalid1,
    output logic [DW-1:0]       rdata,
    output logic                rerr,
    output logic                busy
);

    localparam int AXW = AW + 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            cur_id;
    logic            cur_src;
    logic [AW-1:0]   cur_addr;
    logic            winner;

    logic [AXW-1:0]    addr_ext;
    logic [AXW-1:0]    img_end;
    logic [AXW-1:0]    font_end;
    logic [IMG_W-1:0]  img_word;
    logic [FONT_W-1:0] font_word;
    logic [DW-1:0]     slice_data;
    logic              slice_err;

    // Only meaningful in IDLE when at least one request is present.
    always_comb begin
`ifdef RESOURCE_ARB_FIXED_PRIO_EN
        winner = ~req0;
`else
        if (req0 && req1)
            winner = ~last_grant;
        else
            winner = req1;
`endif
    end

    // The end-of-word bit count is formed in AXW bits so large indices cannot wrap.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        slice_data = '0;
        slice_err  = 1'b0;
        addr_ext   = AXW'(cur_addr);
        img_end    = (addr_ext + AXW'(1)) * AXW'(IMG_W);
        font_end   = (addr_ext + AXW'(1)) * AXW'(FONT_W);
        img_word   = IMG_W'(image_data >> (AXW'(IMG_LEN) - img_end));
        font_word  = FONT_W'(font_data >> (AXW'(FONT_LEN) - font_end));
        if (cur_src) begin
            if (font_end > AXW'(FONT_LEN))
                slice_err = 1'b1;
            else
                slice_data = DW'(font_word);
        end else begin
            if (img_end > AXW'(IMG_LEN))
                slice_err = 1'b1;
            else
                slice_data = DW'(img_word);
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            cur_src    <= 1'b0;
            cur_addr   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata      <= '0;
            rerr       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        cur_id     <= winner;
                        cur_src    <= winner ? src1 : src0;
                        cur_addr   <= winner ? addr1 : addr0;
                        last_grant <= winner;
                        ack0       <= ~winner;
                        ack1       <= winner;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    rdata   <= slice_data;
                    rerr    <= slice_err;
                    rvalid0 <= ~cur_id;
                    rvalid1 <= cur_id;
                    state   <= RESP;
                end
                RESP: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resource_arbiter.sv
// Self-checking bench for resource_arbiter: a transaction-level model predicts every
// cycle's outputs; directed reads pin the model with hand-computed values.
`timescale 1ns/1ps

module tb_resource_arbiter;

    localparam int IMG_LEN  = 48;
    localparam int IMG_W    = 12;
    localparam int FONT_LEN = 16;
    localparam int FONT_W   = 8;
    localparam int AW       = 4;
    localparam int DW       = 16;

    localparam logic [IMG_LEN-1:0]  IMG  = 48'hABC123456789;
    localparam logic [FONT_LEN-1:0] FONT = 16'h5AC3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [IMG_LEN-1:0]  image_data = IMG;
    logic [FONT_LEN-1:0] font_data = FONT;
    logic                req0 = 1'b0, src0 = 1'b0, req1 = 1'b0, src1 = 1'b0;
    logic [AW-1:0]       addr0 = '0, addr1 = '0;
    logic                ack0, ack1, rvalid0, rvalid1, rerr, busy;
    logic [DW-1:0]       rdata;

    resource_arbiter #(
        .IMG_LEN(IMG_LEN), .IMG_W(IMG_W), .FONT_LEN(FONT_LEN),
        .FONT_W(FONT_W), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .image_data(image_data), .font_data(font_data),
        .req0(req0), .src0(src0), .addr0(addr0), .ack0(ack0), .rvalid0(rvalid0),
        .req1(req1), .src1(src1), .addr1(addr1), .ack1(ack1), .rvalid1(rvalid1),
        .rdata(rdata), .rerr(rerr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Transaction model: a grant at edge k shows ack after k, rvalid after k+1,
    // and the next arbitration can happen no earlier than edge k+3.
    int          m_last;
    int          m_free;
    int          m_ack_at, m_ack_port;
    int          m_rv_at, m_rv_port;
    logic [15:0] m_rv_data, m_rdata;
    bit          m_rv_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_word(input bit s, input int a,
                                       output logic [15:0] d, output bit e);
        longint unsigned store;
        int len, w;
        store = s ? longint'(FONT) : longint'(IMG);
        len   = s ? FONT_LEN : IMG_LEN;
        w     = s ? FONT_W : IMG_W;
        if ((a + 1) * w > len) begin
            d = 16'h0;
            e = 1'b1;
        end else begin
            d = 16'((store >> (len - (a + 1) * w)) & ((64'd1 << w) - 1));
            e = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_last   = 1;
        m_free   = 0;
        m_ack_at = -1;
        m_rv_at  = -1;
        m_rdata  = 16'h0;
    endfunction

    function automatic void model_step();
        int w;
        bit s;
        int a;
        if (cyc >= m_free && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef RESOURCE_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = 1 - m_last;
`endif
            end else begin
                w = req1 ? 1 : 0;
            end
            s = (w == 1) ? src1 : src0;
            a = (w == 1) ? int'(addr1) : int'(addr0);
            m_last     = w;
            m_ack_at   = cyc;
            m_ack_port = w;
            m_rv_at    = cyc + 1;
            m_rv_port  = w;
            model_word(s, a, m_rv_data, m_rv_err);
            m_free     = cyc + 3;
        end
        if (cyc == m_rv_at) m_rdata = m_rv_data;
    endfunction

    task automatic compare();
        bit ea0, ea1, ev0, ev1;
        ea0 = (m_ack_at == cyc) && (m_ack_port == 0);
        ea1 = (m_ack_at == cyc) && (m_ack_port == 1);
        ev0 = (m_rv_at == cyc) && (m_rv_port == 0);
        ev1 = (m_rv_at == cyc) && (m_rv_port == 1);
        check("ack0", 32'(ack0), 32'(ea0));
        check("ack1", 32'(ack1), 32'(ea1));
        check("rvalid0", 32'(rvalid0), 32'(ev0));
        check("rvalid1", 32'(rvalid1), 32'(ev1));
        check("busy", 32'(busy), 32'(cyc + 1 < m_free));
        check("rdata", 32'(rdata), 32'(m_rdata));
        if (ev0 || ev1) check("rerr", 32'(rerr), 32'(m_rv_err));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        #1;
        compare();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_read(input int p, input bit s, input int a,
                           input logic [15:0] exp_d, input bit exp_e);
        bit got;
        got = 1'b0;
        if (p == 0) begin req0 = 1'b1; src0 = s; addr0 = AW'(a); end
        else        begin req1 = 1'b1; src1 = s; addr1 = AW'(a); end
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (m_ack_at == cyc && m_ack_port == p) begin
                if (p == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            if (m_rv_at == cyc && m_rv_port == p) got = 1'b1;
        end
        check("rd_done", 32'(got), 32'd1);
        check("rd_data", 32'(rdata), 32'(exp_d));
        check("rd_err", 32'(rerr), 32'(exp_e));
    endtask

    task automatic rand_port(inout logic r, inout logic s, inout logic [AW-1:0] a,
                             input bit acked);
        if (r && acked) begin
            if ($urandom_range(0, 1) == 0) begin
                r = 1'b0;
            end else begin
                s = 1'($urandom_range(0, 1));
                a = AW'($urandom_range(0, 5));
            end
        end else if (!r && $urandom_range(0, 2) == 0) begin
            r = 1'b1;
            s = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 5));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset values
        model_reset();
        step();
        step();
        check("rst_ack", 32'({ack0, ack1}), 32'd0);
        check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check("rst_busy_rerr", 32'({busy, rerr}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Image reads, font reads, out-of-range both stores
        do_read(0, 1'b0, 0, 16'h0ABC, 1'b0);
        do_read(0, 1'b0, 3, 16'h0789, 1'b0);
        do_read(1, 1'b1, 1, 16'h00C3, 1'b0);
        do_read(0, 1'b0, 4, 16'h0000, 1'b1);
        do_read(0, 1'b0, 2, 16'h0456, 1'b0);
        do_read(1, 1'b1, 2, 16'h0000, 1'b1);
        do_read(1, 1'b1, 0, 16'h005A, 1'b0);

        // Both ports held continuously after reset
        reset_dut();
        req0 = 1'b1; src0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; src1 = 1'b1; addr1 = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            step();
`ifdef RESOURCE_ARB_FIXED_PRIO_EN
            if (i % 3 == 1) check("fp_ack1", 32'(ack1), 32'd0);
            if (i % 3 == 2) check("fp_data", 32'(rdata), 32'h0123);
`else
            if (i % 3 == 1) begin
                check("rr_ack0", 32'(ack0), 32'(((i - 1) / 3) % 2 == 0));
                check("rr_ack1", 32'(ack1), 32'(((i - 1) / 3) % 2 == 1));
            end
            if (i % 3 == 2)
                check("rr_data", 32'(rdata), (((i - 2) / 3) % 2 == 0) ? 32'h0123 : 32'h005A);
`endif
        end
`ifdef RESOURCE_ARB_FIXED_PRIO_EN
        // Drop req0 right after its next ack; port 1 is acked three edges later
        for (int i = 0; i < 4 && !(m_ack_at == cyc); i++) step();
        req0 = 1'b0;
        step();
        step();
        step();
        check("fp_port1_ack", 32'(ack1), 32'd1);
`endif
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) step();

        // Reset asserted during FETCH
        req0 = 1'b1; src0 = 1'b0; addr0 = 4'd0;
        req1 = 1'b1; src1 = 1'b1; addr1 = 4'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_ack_at == cyc) break;
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_ack", 32'({ack0, ack1}), 32'd0);
        check("arst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdata", 32'(rdata), 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_grant0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) step();

        // Randomized traffic following the hold-until-ack protocol
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            step();
            rand_port(req0, src0, addr0, (m_ack_at == cyc) && (m_ack_port == 0));
            rand_port(req1, src1, addr1, (m_ack_at == cyc) && (m_ack_port == 1));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
